mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one sequential 8x8 multiplier (start/done datapath + mult_control) among NUM_REQ requesters.
//  Round-robin arbitration, operand muxing, one-cycle start pulse, completion detection and timeout.
//  Returns the product to the granted requester with a one-cycle ack.
//  Sits between the requesting blocks and the multiplier top level.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  W            8   operand width; product is 2*W
//  TIMEOUT_CYC  15  max cycles in BUSY before forced completion with err
// PORTS
//  clk          in   1          clock, rising edge
//  reset_a      in   1          asynchronous, active-high reset
//  req          in   NUM_REQ    request level per requester; held with operands until its ack
//  opa_bus      in   NUM_REQ*W  operand A, requester i at [i*W +: W]
//  opb_bus      in   NUM_REQ*W  operand B, same packing
//  gnt          out  NUM_REQ    one-hot grant, high GRANT..RESP inclusive
//  ack          out  NUM_REQ    one-cycle completion pulse to the granted requester
//  result       out  2*W        product, valid only while ack != 0
//  err          out  1          timeout flag, valid only while ack != 0
//  busy         out  1          high in every state except IDLE
//  state_out    out  2          current state encoding (debug)
//  mult_start   out  1          one-cycle start pulse to the multiplier
//  mult_dataa   out  W          registered operand A to the multiplier
//  mult_datab   out  W          registered operand B to the multiplier
//  mult_done    in   1          multiplier done level
//  mult_product in   2*W        multiplier product
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, all outputs 0, timeout count 0, done_q 0. Async assert, sync release.
//  - States: IDLE=0, GRANT=1, BUSY=2, RESP=3. All outputs registered or decoded from state/registers.
//  - IDLE: if any req, pick the first requester at or after ptr (wrapping). Next edge: GRANT; latch index, opa/opb.
//  - GRANT (1 cycle): gnt[idx]=1, mult_start=1, mult_dataa/b=latched operands. Next edge: BUSY; clear tcnt.
//  - BUSY: mult_dataa/b held; completion = mult_done & ~done_q (rising edge); done_q registered every cycle.
//    A done level held over from a previous operation is not a completion.
//    On completion: latch mult_product into result, err=0. Next edge: RESP.
//    tcnt increments each BUSY cycle. At tcnt==TIMEOUT_CYC-1 with no completion: result=0, err=1. Next edge: RESP.
//    Completion and timeout in the same cycle: completion wins (err=0).
//  - RESP (1 cycle): ack[idx]=1, result/err valid. ptr=(idx+1) mod NUM_REQ. Next edge: IDLE unconditionally.
//  - Latency: req sampled in IDLE at edge 0; mult_start high in cycle 1. ack falls 1 cycle after the done edge is sampled.
//  - Min spacing between grants is 1 IDLE cycle.
//  - req still high in the cycle after ack is a new request, arbitrated against the others. ptr prevents starvation.
//  - req dropped or operands changed after GRANT: ignored. The operation completes and ack still pulses.
//  - Width: result is the full 2*W product, no truncation. 255*255=65025 fits.
//  - Reset mid-operation: immediate return to IDLE, no ack. The multiplier shares reset_a.
// STRUCTURE
//  - Package mult_arb_pkg: state localparams (IDLE/GRANT/BUSY/RESP), defaults NUM_REQ/W/TIMEOUT_CYC, tcnt width.
//  - Sub-module rr_priority_pick: combinational req vector + ptr -> one-hot grant + index + any.
//  - Top holds the FSM, operand/result registers, done edge detect and timeout counter.
// TESTING
//  - Bench has a behavioural multiplier model with programmable done delay; done stays high until the next start.
//  1 req[0], a=12, b=10, done after 5 cycles -> one mult_start pulse, mult_dataa=12, ack[0] with result=120, err=0.
//  2 req=4'b1111, distinct operands, from reset -> acks in order 0,1,2,3. Products correct. gnt never multi-hot.
//  3 req[0] held high, req[2] pulsed per ack -> service order 0,2,0,2. Never two consecutive grants to 0 while 2 waits.
//  4 Model never raises done -> ack after TIMEOUT_CYC BUSY cycles, result=0, err=1. Next request completes normally.
//  5 Stale done: done high entering GRANT, falls, rises 4 cycles later. Operands a=255, b=255 -> result=65025.
//    The stale level must not complete early.
//  6 reset_a asserted mid-BUSY -> same-cycle outputs 0, state_out=0. After release, req[3] alone is granted first.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter.
// Holds the FSM state encoding (also visible on state_out), the default
// parameter values and the default timeout counter width.
package mult_arb_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int W_DEF           = 8;
  localparam int TIMEOUT_CYC_DEF = 15;
  localparam int TCNT_W          = $clog2(TIMEOUT_CYC_DEF + 1);

  // Encoding is visible on state_out, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
// Scans the request vector starting at ptr_i and wrapping, and returns the
// first active requester.
//   req_i     : request vector
//   ptr_i     : index with highest priority this round
//   onehot_o  : one-hot selection (all zero when nothing requests)
//   idx_o     : binary index of the selection
//   any_o     : at least one request is active
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  // First active request at or after ptr_i, wrapping past NUM_REQ-1.
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    onehot_o = {NUM_REQ{1'b0}};
    idx_o    = {IW{1'b0}};
    any_o    = 1'b0;
    j        = 0;
    jj       = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end else begin
        j = j;
      end
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o        = 1'b1;
        idx_o        = jj;
        onehot_o[jj] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier among NUM_REQ requesters.
// Round-robin arbitration, operand capture, a one-cycle start pulse,
// rising-edge completion detection with a timeout, and a one-cycle ack
// carrying the product back to the granted requester.
//   clk, reset_a          : clock, async active-high reset
//   req / opa_bus/opb_bus : request levels and packed operands (W bits each)
//   gnt                   : one-hot grant, high from GRANT through RESP
//   ack, result, err      : completion pulse, product and timeout flag
//   busy, state_out       : activity flag and raw state (debug)
//   mult_start/dataa/datab: multiplier command side
//   mult_done/product     : multiplier response side
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int W           = W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] opa_bus,
  input  logic [NUM_REQ*W-1:0] opb_bus,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2*W-1:0]       result,
  output logic                 err,
  output logic                 busy,
  output logic [1:0]           state_out,
  output logic                 mult_start,
  output logic [W-1:0]         mult_dataa,
  output logic [W-1:0]         mult_datab,
  input  logic                 mult_done,
  input  logic [2*W-1:0]       mult_product
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_REQ-1:0]   sel_q, sel_d;
  logic [W-1:0]         opa_q, opa_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [2*W-1:0]       result_q, result_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 done_q;

  logic [NUM_REQ-1:0]   pick_onehot_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 pick_any_s;
  logic                 done_rise_s;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // A done level left over from the previous operation must not count,
  // so completion is the rising edge only.
  assign done_rise_s = mult_done & ~done_q;

  // Next-state, capture and timeout logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d = ST_GRANT;
          idx_d   = pick_idx_s;
          sel_d   = pick_onehot_s;
          opa_d   = opa_bus[int'(pick_idx_s)*W +: W];
          opb_d   = opb_bus[int'(pick_idx_s)*W +: W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d = ST_BUSY;
        tcnt_d  = {TW{1'b0}};
      end
      ST_BUSY: begin
        // Completion beats a simultaneous timeout.
        if (done_rise_s) begin
          state_d  = ST_RESP;
          result_d = mult_product;
          err_d    = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d  = ST_RESP;
          result_d = {(2*W){1'b0}};
          err_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (idx_q == IW'(NUM_REQ - 1)) begin
          ptr_d = {IW{1'b0}};
        end else begin
          ptr_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q  <= ST_IDLE;
      ptr_q    <= {IW{1'b0}};
      idx_q    <= {IW{1'b0}};
      sel_q    <= {NUM_REQ{1'b0}};
      opa_q    <= {W{1'b0}};
      opb_q    <= {W{1'b0}};
      result_q <= {(2*W){1'b0}};
      err_q    <= 1'b0;
      tcnt_q   <= {TW{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
      done_q   <= mult_done;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign gnt        = busy ? sel_q : {NUM_REQ{1'b0}};
  assign ack        = (state_q == ST_RESP) ? sel_q : {NUM_REQ{1'b0}};
  assign result     = result_q;
  assign err        = err_q;
  assign state_out  = state_q;
  assign mult_start = (state_q == ST_GRANT);
  assign mult_dataa = opa_q;
  assign mult_datab = opb_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier with programmable done
// delay and stale-done hold, a transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, and random
// traffic.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             reset_a;
  logic [N-1:0]     req;
  logic [N*W-1:0]   opa_bus, opb_bus;
  logic [N-1:0]     gnt, ack;
  logic [2*W-1:0]   result;
  logic             err, busy, mult_start;
  logic [1:0]       state_out;
  logic [W-1:0]     mult_dataa, mult_datab;
  logic             mult_done;
  logic [2*W-1:0]   mult_product;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mult_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_a(reset_a), .req(req), .opa_bus(opa_bus), .opb_bus(opb_bus),
    .gnt(gnt), .ack(ack), .result(result), .err(err), .busy(busy),
    .state_out(state_out), .mult_start(mult_start), .mult_dataa(mult_dataa),
    .mult_datab(mult_datab), .mult_done(mult_done), .mult_product(mult_product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t: bound expired", nm, $time);
  endtask

  // ---------------- behavioural multiplier ----------------
  int mm_delay = 1;   // cycles after start until done rises; <=0 means never
  int mm_hold  = 0;   // cycles a stale done stays high after start
  int mm_cnt, mm_hcnt;

  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      mult_done    <= 1'b0;
      mult_product <= 16'd0;
      mm_cnt       <= 0;
      mm_hcnt      <= 0;
    end else if (mult_start) begin
      mult_done    <= (mm_hold > 0);
      mm_hcnt      <= mm_hold;
      mm_cnt       <= (mm_delay > 0) ? mm_delay : 0;
      mult_product <= {8'd0, mult_dataa} * {8'd0, mult_datab};
    end else begin
      if (mm_hcnt > 0) begin
        mm_hcnt <= mm_hcnt - 1;
        if (mm_hcnt == 1) mult_done <= 1'b0;
      end
      if (mm_cnt > 0) begin
        mm_cnt <= mm_cnt - 1;
        if (mm_cnt == 1) mult_done <= 1'b1;
      end
    end
  end

  // ---------------- reference model (transaction view) ----------------
  int          m_owner, m_ptr, m_wait;
  bit          m_fresh, m_resp, m_err, m_prev_done;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_res;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      m_owner <= -1; m_ptr <= 0; m_wait <= 0;
      m_fresh <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0; m_prev_done <= 1'b0;
      m_a <= 8'd0; m_b <= 8'd0; m_res <= 16'd0;
    end else begin
      m_prev_done <= mult_done;
      if (m_owner < 0) begin
        if (rr_pick(req, m_ptr) >= 0) begin
          m_owner <= rr_pick(req, m_ptr);
          m_a     <= opa_bus[rr_pick(req, m_ptr)*W +: W];
          m_b     <= opb_bus[rr_pick(req, m_ptr)*W +: W];
          m_fresh <= 1'b1;
        end
      end else if (m_fresh) begin
        m_fresh <= 1'b0;
        m_wait  <= 0;
      end else if (m_resp) begin
        m_ptr   <= (m_owner + 1) % N;
        m_owner <= -1;
        m_resp  <= 1'b0;
      end else if (mult_done && !m_prev_done) begin
        m_resp <= 1'b1;
        m_res  <= {8'd0, m_a} * {8'd0, m_b};
        m_err  <= 1'b0;
      end else if (m_wait == TO - 1) begin
        m_resp <= 1'b1;
        m_res  <= 16'd0;
        m_err  <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  logic [N-1:0] exp_gnt, exp_ack;
  logic [1:0]   exp_state;
  assign exp_gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  assign exp_ack   = (m_owner >= 0 && m_resp) ? (4'b0001 << m_owner) : 4'b0000;
  assign exp_state = (m_owner < 0) ? 2'd0 : (m_fresh ? 2'd1 : (m_resp ? 2'd3 : 2'd2));

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !reset_a) begin
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("state_out", 32'(state_out), 32'(exp_state));
      chk("mult_start", 32'(mult_start), 32'(m_owner >= 0 && m_fresh));
      chk("mult_dataa", 32'(mult_dataa), 32'(m_a));
      chk("mult_datab", 32'(mult_datab), 32'(m_b));
      if (exp_ack != 4'b0000) begin
        chk("result", 32'(result), 32'(m_res));
        chk("err", 32'(err), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int rem[N];
  int order[$];
  bit rand_mult = 1'b0;

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    opa_bus[i*W +: W] = a;
    opb_bus[i*W +: W] = b;
  endtask

  task automatic wait_ack(output int n, output int starts, output logic [7:0] sa);
    n = 0; starts = 0; sa = 8'd0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (mult_start) begin
        starts++;
        sa = mult_dataa;
      end
      if (ack != 4'b0000) begin
        n = c;
        return;
      end
    end
    fail_bound("ack_wait");
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50; c++) begin
      if (!busy) return;
      @(negedge clk);
    end
    fail_bound("idle_wait");
  endtask

  task automatic run_auto(input int budget);
    bit all_done;
    for (int i = 0; i < N; i++) req[i] = (rem[i] > 0);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (rand_mult) begin
        mm_hold  = $urandom_range(0, 2);
        mm_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(mm_hold + 2, 20));
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          order.push_back(i);
          rem[i]--;
          if (rem[i] <= 0) req[i] = 1'b0;
          else set_ops(i, 8'($urandom), 8'($urandom));
        end else if (gnt[i] && $urandom_range(0, 1) == 1) begin
          set_ops(i, 8'($urandom), 8'($urandom));
        end
      end
      all_done = 1'b1;
      for (int i = 0; i < N; i++) if (rem[i] > 0) all_done = 1'b0;
      if (all_done) return;
    end
    fail_bound("run_auto");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_a = 1'b1;
    req     = 4'b0000;
    @(negedge clk);
    reset_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st;
    logic [7:0] sa;
    int exp3[4];
    reset_a = 1'b1;
    req     = 4'b0000;
    opa_bus = '0;
    opb_bus = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_start", 32'(mult_start), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset_a = 1'b0;
    chk_en  = 1'b1;

    // 1: single request, 12*10, done after 5 cycles
    mm_delay = 5; mm_hold = 0;
    @(negedge clk);
    set_ops(0, 8'd12, 8'd10);
    req[0] = 1'b1;
    wait_ack(n, st, sa);
    chk("t1_latency", 32'(n), 32'd8);
    chk("t1_starts", 32'(st), 32'd1);
    chk("t1_dataa", 32'(sa), 32'd12);
    chk("t1_ack", 32'(ack), 32'd1);
    chk("t1_result", 32'(result), 32'd120);
    chk("t1_err", 32'(err), 32'd0);
    req[0] = 1'b0;
    wait_idle();

    // 2: all four request from reset -> served 0,1,2,3
    do_reset();
    mm_delay = 3;
    for (int i = 0; i < N; i++) begin
      set_ops(i, 8'(i*17 + 5), 8'(200 - i*11));
      rem[i] = 1;
    end
    order.delete();
    run_auto(400);
    chk("t2_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("t2_order", 32'(order[i]), 32'(i));
    wait_idle();

    // 3: requester 0 persistent, requester 2 re-requesting -> 0,2,0,2
    rem[0] = 2; rem[1] = 0; rem[2] = 2; rem[3] = 0;
    set_ops(0, 8'd3, 8'd4);
    set_ops(2, 8'd9, 8'd11);
    order.delete();
    exp3 = '{0, 2, 0, 2};
    run_auto(400);
    chk("t3_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("t3_order", 32'(order[i]), 32'(exp3[i]));
    wait_idle();

    // 4: multiplier never finishes -> timeout, then a normal operation
    mm_delay = -1;
    @(negedge clk);
    set_ops(1, 8'd7, 8'd9);
    req[1] = 1'b1;
    wait_ack(n, st, sa);
    chk("t4_latency", 32'(n), 32'd17);
    chk("t4_ack", 32'(ack), 32'd2);
    chk("t4_result", 32'(result), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    req[1] = 1'b0;
    wait_idle();
    mm_delay = 4;
    @(negedge clk);
    req[1] = 1'b1;
    wait_ack(n, st, sa);
    chk("t4b_result", 32'(result), 32'd63);
    chk("t4b_err", 32'(err), 32'd0);
    req[1] = 1'b0;
    wait_idle();

    // 5: stale done still high through GRANT, falls, rises later; 255*255
    mm_delay = 6; mm_hold = 2;
    @(negedge clk);
    set_ops(2, 8'd255, 8'd255);
    req[2] = 1'b1;
    wait_ack(n, st, sa);
    chk("t5_latency", 32'(n), 32'd9);
    chk("t5_ack", 32'(ack), 32'd4);
    chk("t5_result", 32'(result), 32'd65025);
    chk("t5_err", 32'(err), 32'd0);
    req[2] = 1'b0;
    mm_hold = 0;
    wait_idle();

    // 6: reset in the middle of BUSY
    mm_delay = -1;
    @(negedge clk);
    set_ops(1, 8'd2, 8'd2);
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset_a = 1'b1;
    #1;
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_ack", 32'(ack), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_state", 32'(state_out), 32'd0);
    chk("t6_start", 32'(mult_start), 32'd0);
    chk("t6_dataa", 32'(mult_dataa), 32'd0);
    req = 4'b0000;
    set_ops(3, 8'd3, 8'd5);
    req[3] = 1'b1;
    mm_delay = 2;
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    chk("t6_first_gnt", 32'(gnt), 32'd8);
    wait_ack(n, st, sa);
    chk("t6_result", 32'(result), 32'd15);
    req[3] = 1'b0;
    wait_idle();

    // 7: random traffic against the model
    rand_mult = 1'b1;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        rem[i] = $urandom_range(0, 3);
        set_ops(i, 8'($urandom), 8'($urandom));
      end
      if (rem[0] + rem[1] + rem[2] + rem[3] == 0) rem[0] = 1;
      order.delete();
      run_auto(2000);
      wait_idle();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
